// File: rtl/aes_pkg.sv
//------------------------------------------------------------------------------
// Module  : aes_pkg
// Brief   : Shared AES-256 wrapper constants and serializer state type.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

    localparam int aes_block_bits_gp     = 128;
    localparam int aes_num_round_keys_gp = 15;
    localparam int aes_result_bits_gp    = aes_block_bits_gp
                                         + aes_num_round_keys_gp * aes_block_bits_gp;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

endpackage

`default_nettype wire

// File: rtl/bsg_aes_result_serializer.sv
//------------------------------------------------------------------------------
// Module  : bsg_aes_result_serializer
// Brief   : Streams a 2048-bit AES result (or its ciphertext only) out as
//           width_p-bit words, MSB word first, over a valid/yumi interface.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bsg_aes_result_serializer
    import aes_pkg::*;
#(
    parameter int width_p    = 32,
    parameter int in_width_p = aes_result_bits_gp
) (
    input  logic                  clk_i,
    input  logic                  reset_i,

    input  logic [in_width_p-1:0] data_i,
    input  logic                  v_i,
    input  logic                  cipher_only_i,
    output logic                  yumi_o,

    output logic [width_p-1:0]    data_o,
    output logic                  v_o,
    output logic                  last_o,
    input  logic                  yumi_i
);

    localparam int c_full_words   = in_width_p / width_p;
    localparam int c_cipher_words = aes_block_bits_gp / width_p;
    localparam int c_cnt_w        = $clog2(c_full_words);

    localparam logic [c_cnt_w-1:0] c_full_max   = c_cnt_w'(c_full_words - 1);
    localparam logic [c_cnt_w-1:0] c_cipher_max = c_cnt_w'(c_cipher_words - 1);

    ser_state_e              r_state;
    ser_state_e              w_state_next;
    logic [c_cnt_w-1:0]      r_count;
    logic                    r_mode;
    logic [in_width_p-1:0]   r_shift;
    logic                    w_last;
    logic                    w_advance;

    assign w_last    = (r_count == (r_mode ? c_cipher_max : c_full_max));
    assign w_advance = (r_state == SEND) & yumi_i & ~w_last;

    // yumi_o is gated by reset so upstream never loses a result during reset
    assign yumi_o = v_i & (r_state == IDLE) & ~reset_i;
    assign v_o    = (r_state == SEND);
    assign last_o = v_o & w_last;
    assign data_o = r_shift[in_width_p-1 -: width_p];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (v_i)              w_state_next = SEND;
            SEND:    if (yumi_i && w_last) w_state_next = IDLE;
            default:                       w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_count <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (yumi_o) begin
                r_count <= '0;
                r_mode  <= cipher_only_i;
            end else if (w_advance) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Payload register carries no reset: its contents are qualified by v_o
    always_ff @(posedge clk_i) begin
        if (yumi_o) begin
            r_shift <= data_i;
        end else if (w_advance) begin
            r_shift <= r_shift << width_p;
        end
    end

    // Downstream may only consume a word that is being offered
    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o)
        else $error("yumi_i asserted while v_o=0");

endmodule

`default_nettype wire

// File: tb/tb_bsg_aes_result_serializer.sv
//------------------------------------------------------------------------------
// Module  : tb_bsg_aes_result_serializer
// Brief   : Self-checking bench for bsg_aes_result_serializer (32- and 128-bit).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bsg_aes_result_serializer;

    localparam int c_w = 32;

    logic          clk = 1'b0;
    logic          rst;

    logic [2047:0] data_i;
    logic          v_i, cipher_only_i, yumi_o;
    logic [31:0]   data_o;
    logic          v_o, last_o, yumi_i;

    logic [2047:0] d128;
    logic          v128, co128, yumi_o128;
    logic [127:0]  data_o128;
    logic          v_o128, last_o128, y128;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bsg_aes_result_serializer #(.width_p(32)) dut (
        .clk_i(clk), .reset_i(rst),
        .data_i(data_i), .v_i(v_i), .cipher_only_i(cipher_only_i), .yumi_o(yumi_o),
        .data_o(data_o), .v_o(v_o), .last_o(last_o), .yumi_i(yumi_i)
    );

    bsg_aes_result_serializer #(.width_p(128)) dut128 (
        .clk_i(clk), .reset_i(rst),
        .data_i(d128), .v_i(v128), .cipher_only_i(co128), .yumi_o(yumi_o128),
        .data_o(data_o128), .v_o(v_o128), .last_o(last_o128), .yumi_i(y128)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2047:0] rand_result();
        logic [2047:0] r;
        for (int i = 0; i < 64; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: word k of a result is bits [2047-k*W -: W]; cipher-only keeps the top 128 bits
    task automatic send(input logic [2047:0] d, input bit co, input int pct, input bit hold_v,
                        input int abort_at, output int acc_wait, output int cycles);
        logic [31:0] exp_q[$];
        int          n;
        int          idx;
        bit          y;
        bit          accepted;
        bit          prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;

        n = (co ? 128 : 2048) / c_w;
        for (int k = 0; k < n; k++) exp_q.push_back(d[2047 - k*c_w -: c_w]);
        acc_wait   = 0;
        cycles     = 0;
        accepted   = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;

        for (int t = 0; t < 20 && !accepted; t++) begin
            @(negedge clk);
            v_i = 1'b1; data_i = d; cipher_only_i = co; yumi_i = 1'b0;
            #1;
            if (yumi_o === 1'b1) accepted = 1'b1;
            else acc_wait++;
        end
        chk("accept", {127'd0, accepted}, 128'd1);
        if (!accepted) return;

        cycles = 1;
        idx    = 0;
        while (idx < n && cycles < 2000) begin
            @(negedge clk);
            if (!hold_v) v_i = 1'b0;
            cipher_only_i = $urandom_range(1);
            y      = ($urandom_range(99) < pct);
            yumi_i = y;
            #1;
            cycles++;
            chk("send_v_o",  {127'd0, v_o},    128'd1);
            chk("send_data", {96'd0, data_o},  {96'd0, exp_q[idx]});
            chk("send_last", {127'd0, last_o}, {127'd0, (idx == n-1)});
            chk("send_no_yumi_o", {127'd0, yumi_o}, 128'd0);
            if (prev_stall) begin
                chk("stall_data", {96'd0, data_o},  {96'd0, prev_data});
                chk("stall_last", {127'd0, last_o}, {127'd0, prev_last});
            end
            prev_stall = !y;
            prev_data  = data_o;
            prev_last  = last_o;
            if (y) begin
                idx++;
                if (idx == abort_at) begin
                    @(posedge clk);
                    #2;
                    rst = 1'b1; v_i = 1'b1; yumi_i = 1'b0;
                    #1;
                    chk("abort_v_o",    {127'd0, v_o},    128'd0);
                    chk("abort_last_o", {127'd0, last_o}, 128'd0);
                    chk("abort_yumi_o", {127'd0, yumi_o}, 128'd0);
                    @(negedge clk);
                    v_i = 1'b0; rst = 1'b0;
                    return;
                end
            end
        end
        chk("send_complete", idx, n);
        if (!hold_v) begin
            @(negedge clk);
            yumi_i = 1'b0;
            #1;
            chk("after_v_o", {127'd0, v_o}, 128'd0);
        end
    endtask

    initial begin
        logic [2047:0] inc, r1, r2;
        logic [127:0]  fips;
        int            w, c, w2, c2;

        for (int k = 0; k < 64; k++) inc[2047 - k*32 -: 32] = k;
        fips = 128'h8ea2b7ca516745bfeafc49904b496089;

        rst = 1'b1; v_i = 1'b1; data_i = inc; cipher_only_i = 1'b0; yumi_i = 1'b0;
        v128 = 1'b1; d128 = '0; co128 = 1'b1; y128 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_v_o",       {127'd0, v_o},       128'd0);
        chk("reset_last_o",    {127'd0, last_o},    128'd0);
        chk("reset_yumi_o",    {127'd0, yumi_o},    128'd0);
        chk("reset_v_o128",    {127'd0, v_o128},    128'd0);
        chk("reset_last_o128", {127'd0, last_o128}, 128'd0);
        chk("reset_yumi_o128", {127'd0, yumi_o128}, 128'd0);
        @(negedge clk);
        rst = 1'b0; v_i = 1'b0; v128 = 1'b0;

        // Full result, no backpressure
        send(inc, 1'b0, 100, 1'b0, -1, w, c);
        chk("full_accept_wait", w, 0);
        chk("full_cycles", c, 65);

        // Cipher-only with v_i held through SEND
        send(inc, 1'b1, 100, 1'b1, -1, w, c);
        chk("cipher_cycles", c, 5);
        @(negedge clk);
        v_i = 1'b0; yumi_i = 1'b0;
        #1;
        chk("cipher_after_v_o", {127'd0, v_o}, 128'd0);

        // Random backpressure
        send(rand_result(), 1'b0, 50, 1'b0, -1, w, c);

        // Back-to-back results
        r1 = rand_result();
        r2 = rand_result();
        send(r1, 1'b0, 100, 1'b1, -1, w, c);
        send(r2, 1'b0, 100, 1'b1, -1, w2, c2);
        chk("b2b_gap", w2, 0);
        chk("b2b_cycles", c, 65);
        @(negedge clk);
        v_i = 1'b0; yumi_i = 1'b0;

        // Asynchronous abort after 10 words, then a clean restart
        send(rand_result(), 1'b0, 100, 1'b0, 10, w, c);
        send(inc, 1'b0, 60, 1'b0, -1, w, c);
        chk("restart_accept_wait", w, 0);

        for (int i = 0; i < 4; i++) send(rand_result(), 1'(i % 2), 70, 1'b0, -1, w, c);

        // 128-bit word, cipher-only: one word carrying the FIPS-197 ciphertext
        @(negedge clk);
        v128 = 1'b1; co128 = 1'b1; y128 = 1'b0;
        d128 = rand_result();
        d128[2047 -: 128] = fips;
        #1;
        chk("w128_yumi_o", {127'd0, yumi_o128}, 128'd1);
        @(negedge clk);
        v128 = 1'b0; y128 = 1'b1;
        #1;
        chk("w128_v_o",  {127'd0, v_o128},    128'd1);
        chk("w128_data", data_o128,           fips);
        chk("w128_last", {127'd0, last_o128}, 128'd1);
        @(negedge clk);
        y128 = 1'b0;
        #1;
        chk("w128_after_v_o", {127'd0, v_o128}, 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
